cmd_ascii_tx: RTL

CMD_ASCII_TX -- requirements
Module: cmd_ascii_tx

---
 rtl/cmd_ascii_tx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cmd_ascii_tx.sv
// cmd_ascii_tx: turns one-cycle command strobes into fixed ASCII messages
// sent one byte at a time over a valid/ready link.
//   clk, reset        : clock, asynchronous active-high reset
//   D,E,B,F,R         : command strobes (STOP, PLAY, BWD, FWD, RST)
//   tx_data, tx_valid : byte offered downstream (tx_data is 0 when not valid)
//   tx_ready          : sink accepts tx_data this cycle
//   busy              : message in progress or pending
//   overflow          : sticky, a pending command was overwritten
module cmd_ascii_tx #(
  parameter logic [7:0] TERM_CHAR = 8'h0D,
  parameter bit         TERM_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       D,
  input  logic       E,
  input  logic       B,
  input  logic       F,
  input  logic       R,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overflow
);

  typedef enum logic {IDLE, SEND} state_t;
  typedef enum logic [2:0] {C_STOP, C_PLAY, C_FWD, C_BWD, C_RST} cmd_t;

  state_t     state, state_n;
  cmd_t       cur, cur_n, pend, pend_n, code;
  logic [2:0] idx, idx_n, len;
  logic       pend_v, pend_v_n, ovf, ovf_n;
  logic       strobe, xfer, last;
  logic [31:0] word;

  // Fixed priority R > D > E > F > B; losers in the same cycle are dropped.
  always_comb begin
    strobe = R | D | E | F | B;
    code   = C_BWD;
    if (R)      code = C_RST;
    else if (D) code = C_STOP;
    else if (E) code = C_PLAY;
    else if (F) code = C_FWD;
  end

  // Letters left-aligned in a 32-bit word; 3-letter words padded with 0.
  always_comb begin
    case (cur)
      C_STOP:  word = 32'h5354_4F50;
      C_PLAY:  word = 32'h504C_4159;
      C_FWD:   word = 32'h4657_4400;
      C_BWD:   word = 32'h4257_4400;
      default: word = 32'h5253_5400;
    endcase
  end

  always_comb begin
    len = ((cur == C_STOP) || (cur == C_PLAY)) ? 3'd4 : 3'd3;
    len = len + 3'(TERM_EN);
  end

  assign xfer = (state == SEND) && tx_ready;
  assign last = (idx == len - 3'd1);

  always_comb begin
    state_n  = state;
    cur_n    = cur;
    idx_n    = idx;
    pend_v_n = pend_v;
    pend_n   = pend;
    ovf_n    = ovf;
    case (state)
      IDLE: if (strobe) begin
        state_n = SEND;
        cur_n   = code;
        idx_n   = 3'd0;
      end
      default: begin
        // New strobes only ever touch the pending slot, never the live message.
        if (strobe) begin
          pend_v_n = 1'b1;
          pend_n   = code;
          if (pend_v) ovf_n = 1'b1;
        end
        if (xfer) begin
          if (!last) begin
            idx_n = idx + 3'd1;
          end else if (pend_v_n) begin
            // Chain straight into the pending message with no idle cycle.
            cur_n    = pend_n;
            idx_n    = 3'd0;
            pend_v_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cur    <= C_STOP;
      idx    <= 3'd0;
      pend_v <= 1'b0;
      pend   <= C_STOP;
      ovf    <= 1'b0;
    end else begin
      state  <= state_n;
      cur    <= cur_n;
      idx    <= idx_n;
      pend_v <= pend_v_n;
      pend   <= pend_n;
      ovf    <= ovf_n;
    end
  end

  always_comb begin
    tx_valid = (state == SEND);
    tx_data  = 8'h00;
    if (tx_valid) begin
      case (idx)
        3'd0:    tx_data = word[31:24];
        3'd1:    tx_data = word[23:16];
        3'd2:    tx_data = word[15:8];
        3'd3:    tx_data = (len > 3'd4 || (len == 3'd4 && (cur == C_STOP || cur == C_PLAY)))
                           ? word[7:0] : TERM_CHAR;
        default: tx_data = TERM_CHAR;
      endcase
    end
    busy     = tx_valid | pend_v;
    overflow = ovf;
  end

endmodule
